// File: rtl/sram_ctrl_if.sv
// CPU-side load/store handshake and 16-bit asynchronous SRAM pins for sram_ctrl.
// The slave modport is the controller's view; the master modport is the
// CPU pipeline plus SRAM device that surround it.
interface sram_ctrl_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    modport slave (
        input  rd_en, wr_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport master (
        output rd_en, wr_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/sram_ctrl.sv
// Splits one 32-bit CPU load/store into two timed 16-bit SRAM half-accesses
// (low half, then high half) and stalls the pipeline via ready until done.
module sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic       clk,
    input  logic       rst,
    sram_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

    // Counter value on the final cycle of a LOW or HIGH phase.
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] read_data_q, read_data_d;
    logic [17:0] sram_addr_q, sram_addr_d;
    logic [15:0] dq_out_q, dq_out_d;
    logic        we_n_q, we_n_d;
    logic        oe_q, oe_d;
    logic [31:0] offset_d;
    logic        req;
    logic        unused_offset_bits;

    assign req = bus.rd_en | bus.wr_en;

    // Only bits [18:2] of the rebased address reach the 17-bit word index.
    assign unused_offset_bits = ^{offset_d[31:19], offset_d[1:0]};

    // Sequencing: accept a request in IDLE, time each half, capture read halves.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q + 4'd1;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        is_wr_d     = is_wr_q;
        read_data_d = read_data_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req) begin
                    // A store wins when both enables are high.
                    addr_d  = bus.address;
                    wdata_d = bus.write_data;
                    is_wr_d = bus.wr_en;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = HIGH;
                    if (!is_wr_q) read_data_d[15:0] = bus.sram_dq_in;
                end
            end
            HIGH: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    if (!is_wr_q) read_data_d[31:16] = bus.sram_dq_in;
                end
            end
            default: begin
                // DONE lasts one cycle and never restarts the same request.
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // SRAM pin values for the state being entered, so pins change only on edges.
    always_comb begin
        offset_d    = addr_d - BASE_ADDR;
        sram_addr_d = '0;
        dq_out_d    = '0;
        we_n_d      = 1'b1;
        oe_d        = 1'b0;
        case (state_d)
            LOW: begin
                sram_addr_d = {offset_d[18:2], 1'b0};
                if (is_wr_d) begin
                    we_n_d   = 1'b0;
                    oe_d     = 1'b1;
                    dq_out_d = wdata_d[15:0];
                end
            end
            HIGH: begin
                sram_addr_d = {offset_d[18:2], 1'b1};
                if (is_wr_d) begin
                    we_n_d   = 1'b0;
                    oe_d     = 1'b1;
                    dq_out_d = wdata_d[31:16];
                end
            end
            default: ;
        endcase
    end

    // State and pin registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            is_wr_q     <= 1'b0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            we_n_q      <= 1'b1;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            is_wr_q     <= is_wr_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            we_n_q      <= we_n_d;
            oe_q        <= oe_d;
        end
    end

    assign bus.ready       = ~req | (state_q == DONE);
    assign bus.read_data   = read_data_q;
    assign bus.sram_addr   = sram_addr_q;
    assign bus.sram_dq_out = dq_out_q;
    assign bus.sram_we_n   = we_n_q;
    assign bus.sram_dq_oe  = oe_q;

endmodule
